// File: rtl/cs_alu_mem.sv
// cs_alu_mem: computational-storage unit. A DEPTH x WIDTH register-file memory with an
// in-place ALU: mem[addC] = mem[addA] op mem[addB], plus host WRITE and READ commands.
// Commands use a valid/ready handshake, and all inputs are sampled on accept.
//
// Optional feature macro: CS_SATURATE_EN. When it is defined, an ADD with a carry-out
// clamps to all-ones and a SUB with a borrow clamps to zero. When it is undefined,
// results wrap modulo 2^WIDTH.
//
// Ports:
//   CLK        - clock, all state updates on the rising edge
//   RESET      - synchronous active-high reset (clears memory, outputs and FSM)
//   req_valid  - command present
//   req_ready  - unit can accept a command (low only while a compute op executes)
//   OPERATION  - opcode: 0 NOP, 1 WRITE, 2 READ, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR
//   addA/addB  - operand addresses (addA is also the READ address)
//   addC       - destination address for WRITE and compute ops
//   DIN        - write data
//   DOUT       - registered read data, holds the last READ value
//   dout_valid - one-cycle strobe after each READ accept
//   overflow   - carry/borrow of the last ADD/SUB, cleared by logic ops

module cs_alu_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       OPERATION,
  input  logic [AW-1:0]    addA,
  input  logic [AW-1:0]    addB,
  input  logic [AW-1:0]    addC,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             dout_valid,
  output logic             overflow
);

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpWrite = 3'd1;
  localparam logic [2:0] OpRead  = 3'd2;
  localparam logic [2:0] OpAdd   = 3'd3;
  localparam logic [2:0] OpSub   = 3'd4;
  localparam logic [2:0] OpAnd   = 3'd5;
  localparam logic [2:0] OpOr    = 3'd6;
  localparam logic [2:0] OpXor   = 3'd7;

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [2:0]       opcode_q;
  logic [AW-1:0]    addr_c_q;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             overflow_q;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] result;
  logic             result_ovf;

  assign req_ready  = (state_q == StIdle);
  assign DOUT       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overflow   = overflow_q;

  // ALU works on the latched operands, so aliasing addC with addA/addB uses the old values.
  always_comb begin
    sum        = {1'b0, op_a_q} + {1'b0, op_b_q};
    diff       = {1'b0, op_a_q} - {1'b0, op_b_q};
    result     = '0;
    result_ovf = 1'b0;
    case (opcode_q)
      OpAdd: begin
        result     = sum[WIDTH-1:0];
        result_ovf = sum[WIDTH];
`ifdef CS_SATURATE_EN
        if (sum[WIDTH]) result = '1;
`endif
      end
      OpSub: begin
        // The top bit of the extended difference is the borrow (A < B).
        result     = diff[WIDTH-1:0];
        result_ovf = diff[WIDTH];
`ifdef CS_SATURATE_EN
        if (diff[WIDTH]) result = '0;
`endif
      end
      OpAnd:   result = op_a_q & op_b_q;
      OpOr:    result = op_a_q | op_b_q;
      OpXor:   result = op_a_q ^ op_b_q;
      default: result = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      // Also aborts an op in EXEC: the pending write is dropped.
      state_q      <= StIdle;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      opcode_q     <= OpNop;
      addr_c_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            case (OPERATION)
              OpNop:   ;
              OpWrite: mem_q[addC] <= DIN;
              OpRead: begin
                dout_q       <= mem_q[addA];
                dout_valid_q <= 1'b1;
              end
              default: begin
                op_a_q   <= mem_q[addA];
                op_b_q   <= mem_q[addB];
                opcode_q <= OPERATION;
                addr_c_q <= addC;
                state_q  <= StExec;
              end
            endcase
          end
        end
        StExec: begin
          mem_q[addr_c_q] <= result;
          overflow_q      <= result_ovf;
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_alu_mem.sv
module tb_cs_alu_mem;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpWrite = 3'd1;
  localparam logic [2:0] OpRead  = 3'd2;
  localparam logic [2:0] OpAdd   = 3'd3;
  localparam logic [2:0] OpSub   = 3'd4;
  localparam logic [2:0] OpAnd   = 3'd5;
  localparam logic [2:0] OpOr    = 3'd6;
  localparam logic [2:0] OpXor   = 3'd7;

`ifdef CS_SATURATE_EN
  localparam logic [7:0] AddOvfRes = 8'hFF;
  localparam logic [7:0] SubOvfRes = 8'h00;
`else
  localparam logic [7:0] AddOvfRes = 8'h10;
  localparam logic [7:0] SubOvfRes = 8'hF0;
`endif

  logic             CLK = 1'b0;
  logic             RESET;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       OPERATION;
  logic [AW-1:0]    addA, addB, addC;
  logic [WIDTH-1:0] DIN;
  logic [WIDTH-1:0] DOUT;
  logic             dout_valid;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  cs_alu_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .OPERATION (OPERATION),
    .addA      (addA),
    .addB      (addB),
    .addC      (addC),
    .DIN       (DIN),
    .DOUT      (DOUT),
    .dout_valid(dout_valid),
    .overflow  (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [7:0] d);
    req_valid = 1'b1;
    OPERATION = op;
    addA      = a;
    addB      = b;
    addC      = c;
    DIN       = d;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    OPERATION = OpNop;
  endtask

  // Single accept edge, inputs released afterwards.
  task automatic cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] c, input logic [7:0] d);
    drive(op, a, b, c, d);
    step();
    idle_inputs();
  endtask

  task automatic wr(input logic [3:0] c, input logic [7:0] d);
    cmd(OpWrite, 4'd0, 4'd0, c, d);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    cmd(OpRead, a, 4'd0, 4'd0, 8'd0);
    check({tag, ".valid"}, 32'(dout_valid), 32'd1);
    check({tag, ".dout"}, 32'(DOUT), 32'(exp));
  endtask

  // Accept, confirm the EXEC bubble, then the writeback edge and overflow result.
  task automatic compute(input string tag, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c, input logic exp_ovf);
    cmd(op, a, b, c, 8'd0);
    check({tag, ".busy"}, 32'(req_ready), 32'd0);
    step();
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    RESET = 1'b1;
    idle_inputs();
    addA = '0;
    addB = '0;
    addC = '0;
    DIN  = '0;

    // Reset state
    step();
    step();
    RESET = 1'b0;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.ovf", 32'(overflow), 32'd0);
    check("rst.valid", 32'(dout_valid), 32'd0);
    check("rst.dout", 32'(DOUT), 32'd0);
    rd("rst.rd5", 4'd5, 8'h00);
    step();
    check("rst.strobe_drop", 32'(dout_valid), 32'd0);
    check("rst.dout_hold", 32'(DOUT), 32'd0);

    // Basic compute with a READ held through the busy cycle
    wr(4'd3, 8'h2A);
    wr(4'd4, 8'h15);
    cmd(OpAdd, 4'd3, 4'd4, 4'd7, 8'd0);
    check("add.busy", 32'(req_ready), 32'd0);
    drive(OpRead, 4'd7, 4'd0, 4'd0, 8'd0);
    step();
    check("add.held_not_taken", 32'(dout_valid), 32'd0);
    check("add.ready", 32'(req_ready), 32'd1);
    check("add.ovf", 32'(overflow), 32'd0);
    step();
    idle_inputs();
    check("add.rd7.valid", 32'(dout_valid), 32'd1);
    check("add.rd7.dout", 32'(DOUT), 32'h3F);

    // Overflow / saturation
    wr(4'd0, 8'hF0);
    wr(4'd1, 8'h20);
    compute("addovf", OpAdd, 4'd0, 4'd1, 4'd5, 1'b1);
    rd("addovf.rd5", 4'd5, AddOvfRes);
    cmd(OpNop, 4'd0, 4'd0, 4'd0, 8'd0);
    check("nop.ovf_hold", 32'(overflow), 32'd1);
    wr(4'd6, 8'h10);
    wr(4'd8, 8'h20);
    compute("sub", OpSub, 4'd6, 4'd8, 4'd10, 1'b1);
    rd("sub.rd10", 4'd10, SubOvfRes);
    check("rd.ovf_hold", 32'(overflow), 32'd1);
    wr(4'd11, 8'h0F);
    wr(4'd12, 8'hFF);
    compute("xor", OpXor, 4'd11, 4'd12, 4'd13, 1'b0);
    rd("xor.rd13", 4'd13, 8'hF0);
    compute("subnb", OpSub, 4'd8, 4'd6, 4'd14, 1'b0);
    rd("subnb.rd14", 4'd14, 8'h10);
    wr(4'd14, 8'hCC);
    wr(4'd15, 8'hAA);
    compute("and", OpAnd, 4'd14, 4'd15, 4'd2, 1'b0);
    rd("and.rd2", 4'd2, 8'h88);
    compute("or", OpOr, 4'd14, 4'd15, 4'd3, 1'b0);
    rd("or.rd3", 4'd3, 8'hEE);

    // Aliasing and back-to-back WRITE -> READ
    wr(4'd1, 8'h05);
    compute("alias", OpAdd, 4'd1, 4'd1, 4'd1, 1'b0);
    rd("alias.rd1", 4'd1, 8'h0A);
    wr(4'd9, 8'hA5);
    rd("b2b.rd9", 4'd9, 8'hA5);

    // Reset in EXEC aborts the op; set overflow first so its clearing is visible
    compute("presub", OpSub, 4'd6, 4'd8, 4'd0, 1'b1);
    wr(4'd2, 8'h11);
    cmd(OpAdd, 4'd2, 4'd2, 4'd2, 8'd0);
    check("midrst.busy", 32'(req_ready), 32'd0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("midrst.ready", 32'(req_ready), 32'd1);
    check("midrst.ovf", 32'(overflow), 32'd0);
    check("midrst.dout", 32'(DOUT), 32'd0);
    rd("midrst.rd2", 4'd2, 8'h00);
    rd("midrst.rd9", 4'd9, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time limit so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
